// File: rtl/glasscell_pkg.sv
// Shared types for the cache arbiter: FSM states, access widths, requester ids
// and small helpers for alignment checks and read-data extension.
package glasscell_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StAck    = 2'b10
  } arbState_e;

  typedef enum logic [1:0] {
    WidthByte = 2'b00,
    WidthHalf = 2'b01,
    WidthWord = 2'b10,
    WidthRsvd = 2'b11
  } memWidth_e;

  typedef enum logic {
    ReqInstr = 1'b0,
    ReqData  = 1'b1
  } reqId_e;

  // True when a data access cannot be issued: reserved width or misaligned address.
  function automatic logic isBadAccess(input logic [1:0] width, input logic [1:0] addrLow);
    logic bad;
    bad = 1'b0;
    if (width == WidthRsvd) begin
      bad = 1'b1;
    end else if (width == WidthHalf) begin
      bad = addrLow[0];
    end else if (width == WidthWord) begin
      bad = (addrLow != 2'b00);
    end
    return bad;
  endfunction

  // Zero-extend the low bits of a memory read according to the access width.
  function automatic logic [31:0] zeroExtend(input logic [1:0] width, input logic [31:0] data);
    logic [31:0] ext;
    ext = data;
    if (width == WidthByte) begin
      ext = {24'h000000, data[7:0]};
    end else if (width == WidthHalf) begin
      ext = {16'h0000, data[15:0]};
    end
    return ext;
  endfunction

endpackage

// File: rtl/grant_select.sv
// Combinational winner selection between the instruction and data ports.
// On a tie the port that did not receive the previous grant wins; the top feeds
// a constant LastGrant when round-robin arbitration is disabled.
module grant_select
  import glasscell_pkg::*;
(
  input  logic   IReq,
  input  logic   DReq,
  input  reqId_e LastGrant,
  output reqId_e Grant
);

  // Pick the winner; data is the default when nothing is requesting.
  always_comb begin
    Grant = ReqData;
    if (IReq && DReq) begin
      if (LastGrant == ReqData) begin
        Grant = ReqInstr;
      end else begin
        Grant = ReqData;
      end
    end else if (IReq) begin
      Grant = ReqInstr;
    end else begin
      Grant = ReqData;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port cache arbiter: instruction and data requesters share one memory port,
// one transaction in flight at a time (IDLE -> ACCESS -> ACK).
// Optional macro CACHE_ARBITER_ROUND_ROBIN_EN: alternate ties between ports;
// when undefined, data always wins ties and no LastGrant register exists.
module cache_arbiter
  import glasscell_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        IReq,
  input  logic [31:0] IAddress,
  output logic [31:0] IData,
  output logic        IAck,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [1:0]  DWidth,
  input  logic [31:0] DAddress,
  input  logic [31:0] DWriteData,
  output logic [31:0] DReadData,
  output logic        DAck,
  output logic        DError,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [1:0]  MemWidth,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData,
  input  logic        MemReady
);

  arbState_e   stateQ, stateD;
  reqId_e      ownerQ;
  reqId_e      winner;
  reqId_e      lastGrant;
  logic        writeQ;
  logic [1:0]  widthQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic        errorQ;
  logic [31:0] iDataQ;
  logic [31:0] dDataQ;
  logic        anyReq;
  logic        dBad;
  logic        grantTaken;

  assign anyReq     = IReq | DReq;
  assign dBad       = isBadAccess(DWidth, DAddress[1:0]);
  assign grantTaken = (stateQ == StIdle) && anyReq;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  reqId_e lastGrantQ;

  // Remember who was granted last; reset value makes the first tie go to instruction.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lastGrantQ <= ReqData;
    end else if (grantTaken) begin
      lastGrantQ <= winner;
    end
  end

  assign lastGrant = lastGrantQ;
`else
  // Naming instruction as last grant makes every tie resolve to data.
  assign lastGrant = ReqInstr;
`endif

  grant_select u_grantSelect (
    .IReq      (IReq),
    .DReq      (DReq),
    .LastGrant (lastGrant),
    .Grant     (winner)
  );

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic; rejected data requests bypass the memory access entirely.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      StIdle: begin
        if (anyReq) begin
          if ((winner == ReqData) && dBad) begin
            stateD = StAck;
          end else begin
            stateD = StAccess;
          end
        end
      end
      StAccess: begin
        if (MemReady) begin
          stateD = StAck;
        end
      end
      StAck: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  // Latch the winner's request fields when the grant is taken.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ownerQ <= ReqInstr;
      writeQ <= 1'b0;
      widthQ <= WidthByte;
      addrQ  <= 32'h0;
      wdataQ <= 32'h0;
      errorQ <= 1'b0;
    end else if (grantTaken) begin
      ownerQ <= winner;
      if (winner == ReqData) begin
        writeQ <= DWrite;
        widthQ <= DWidth;
        addrQ  <= DAddress;
        wdataQ <= DWriteData;
        errorQ <= dBad;
      end else begin
        // Instruction fetches are always word reads.
        writeQ <= 1'b0;
        widthQ <= WidthWord;
        addrQ  <= IAddress;
        wdataQ <= 32'h0;
        errorQ <= 1'b0;
      end
    end
  end

  // Capture read data on completion; values hold between transactions.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      iDataQ <= 32'h0;
      dDataQ <= 32'h0;
    end else if ((stateQ == StAccess) && MemReady) begin
      if (ownerQ == ReqInstr) begin
        iDataQ <= MemReadData;
      end else if (!writeQ) begin
        dDataQ <= zeroExtend(widthQ, MemReadData);
      end
    end else if (grantTaken && (winner == ReqData) && dBad) begin
      dDataQ <= 32'h0;
    end
  end

  assign MemReq       = (stateQ == StAccess);
  assign MemWrite     = writeQ;
  assign MemWidth     = widthQ;
  assign MemAddress   = addrQ;
  assign MemWriteData = wdataQ;

  assign IAck      = (stateQ == StAck) && (ownerQ == ReqInstr);
  assign DAck      = (stateQ == StAck) && (ownerQ == ReqData);
  assign DError    = DAck && errorQ;
  assign IData     = iDataQ;
  assign DReadData = dDataQ;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        IReq;
  logic [31:0] IAddress;
  logic [31:0] IData;
  logic        IAck;
  logic        DReq;
  logic        DWrite;
  logic [1:0]  DWidth;
  logic [31:0] DAddress;
  logic [31:0] DWriteData;
  logic [31:0] DReadData;
  logic        DAck;
  logic        DError;
  logic        MemReq;
  logic        MemWrite;
  logic [1:0]  MemWidth;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic [31:0] MemReadData;
  logic        MemReady;

  int tests = 0;
  int failures = 0;

  cache_arbiter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .IReq         (IReq),
    .IAddress     (IAddress),
    .IData        (IData),
    .IAck         (IAck),
    .DReq         (DReq),
    .DWrite       (DWrite),
    .DWidth       (DWidth),
    .DAddress     (DAddress),
    .DWriteData   (DWriteData),
    .DReadData    (DReadData),
    .DAck         (DAck),
    .DError       (DError),
    .MemReq       (MemReq),
    .MemWrite     (MemWrite),
    .MemWidth     (MemWidth),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemReadData  (MemReadData),
    .MemReady     (MemReady)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Single-beat data read answered in the first ACCESS cycle.
  task automatic dRead(input string tag, input logic [1:0] width, input logic [31:0] addr,
                       input logic [31:0] memData, input logic [31:0] expData);
    DReq = 1'b1; DWrite = 1'b0; DWidth = width; DAddress = addr;
    tick;
    check({tag, "_memReq"}, 32'(MemReq), 32'd1);
    check({tag, "_memWidth"}, 32'(MemWidth), 32'(width));
    MemReady = 1'b1; MemReadData = memData;
    tick;
    check({tag, "_dAck"}, 32'(DAck), 32'd1);
    check({tag, "_data"}, DReadData, expData);
    check({tag, "_dError"}, 32'(DError), 32'd0);
    DReq = 1'b0; MemReady = 1'b0;
    tick;
  endtask

  // Rejected data request: acknowledged in cycle 1 with an error, never reaches memory.
  task automatic dErr(input string tag, input logic [1:0] width, input logic [31:0] addr);
    DReq = 1'b1; DWrite = 1'b0; DWidth = width; DAddress = addr;
    tick;
    check({tag, "_dAck"}, 32'(DAck), 32'd1);
    check({tag, "_dError"}, 32'(DError), 32'd1);
    check({tag, "_data"}, DReadData, 32'h0);
    check({tag, "_memReq1"}, 32'(MemReq), 32'd0);
    DReq = 1'b0;
    tick;
    check({tag, "_dErrorClr"}, 32'(DError), 32'd0);
    check({tag, "_memReq2"}, 32'(MemReq), 32'd0);
  endtask

  // Both ports request together; serve until both are acked. 1 = data, 0 = instruction.
  task automatic runTie(output logic g0, output logic g1);
    int n;
    n = 0; g0 = 1'bx; g1 = 1'bx;
    IReq = 1'b1; IAddress = 32'h104;
    DReq = 1'b1; DWrite = 1'b0; DWidth = 2'b10; DAddress = 32'h80;
    for (int c = 0; c < 20 && n < 2; c++) begin
      tick;
      MemReady = 1'b0;
      if (IAck || DAck) begin
        if (n == 0) g0 = DAck; else g1 = DAck;
        n++;
        if (IAck) IReq = 1'b0; else DReq = 1'b0;
      end
      if (MemReq) begin
        MemReady = 1'b1; MemReadData = 32'h0A0A0A0A;
      end
    end
    check("tieDone", 32'(n), 32'd2);
    IReq = 1'b0; DReq = 1'b0; MemReady = 1'b0;
    tick;
  endtask

  logic       t0, t1, t2, t3;
  logic [3:0] expGrants;

  initial begin
    Reset = 1'b1; IReq = 1'b0; IAddress = 32'h0; DReq = 1'b0; DWrite = 1'b0;
    DWidth = 2'b00; DAddress = 32'h0; DWriteData = 32'h0; MemReadData = 32'h0;
    MemReady = 1'b0;
    tick;
    tick;
    check("rst_memReq", 32'(MemReq), 32'd0);
    check("rst_acks", {30'd0, IAck, DAck}, 32'd0);
    check("rst_dError", 32'(DError), 32'd0);
    check("rst_iData", IData, 32'h0);
    check("rst_dData", DReadData, 32'h0);
    check("rst_memAddr", MemAddress, 32'h0);
    check("rst_memWidth", 32'(MemWidth), 32'd0);
    Reset = 1'b0;

    // Stray MemReady while idle does nothing.
    MemReady = 1'b1;
    tick;
    check("idleReady_memReq", 32'(MemReq), 32'd0);
    check("idleReady_acks", {30'd0, IAck, DAck}, 32'd0);
    MemReady = 1'b0;

    // Instruction fetch, memory answers in cycle 1.
    IReq = 1'b1; IAddress = 32'h100;
    tick;
    check("i_memReq", 32'(MemReq), 32'd1);
    check("i_memAddr", MemAddress, 32'h100);
    check("i_memWrite", 32'(MemWrite), 32'd0);
    check("i_memWidth", 32'(MemWidth), 32'd2);
    check("i_noAckYet", 32'(IAck), 32'd0);
    MemReady = 1'b1; MemReadData = 32'hDEADBEEF;
    tick;
    check("i_ack", 32'(IAck), 32'd1);
    check("i_data", IData, 32'hDEADBEEF);
    check("i_memReqDrop", 32'(MemReq), 32'd0);
    check("i_noDAck", 32'(DAck), 32'd0);
    IReq = 1'b0; MemReady = 1'b0;
    tick;
    check("i_ackPulse", 32'(IAck), 32'd0);
    check("i_dataHold", IData, 32'hDEADBEEF);

    // Byte write, memory ready after three wait cycles -> ack in cycle 5.
    DReq = 1'b1; DWrite = 1'b1; DWidth = 2'b00; DAddress = 32'h203; DWriteData = 32'h55;
    for (int c = 1; c <= 4; c++) begin
      tick;
      check("w_memReq", 32'(MemReq), 32'd1);
      check("w_noAck", 32'(DAck), 32'd0);
      if (c == 1) begin
        check("w_memWrite", 32'(MemWrite), 32'd1);
        check("w_memWidth", 32'(MemWidth), 32'd0);
        check("w_memAddr", MemAddress, 32'h203);
        check("w_memWData", MemWriteData, 32'h55);
      end
      if (c == 4) begin
        MemReady = 1'b1; MemReadData = 32'h11111111;
      end
    end
    tick;
    check("w_dAck", 32'(DAck), 32'd1);
    check("w_dError", 32'(DError), 32'd0);
    check("w_dataUnchanged", DReadData, 32'h0);
    check("w_memReqDrop", 32'(MemReq), 32'd0);
    DReq = 1'b0; DWrite = 1'b0; MemReady = 1'b0;
    tick;

    // Reads of each width, zero-extended.
    dRead("rByteOdd", 2'b00, 32'h41, 32'hCAFEBA98, 32'h00000098);
    dRead("rHalf", 2'b01, 32'h42, 32'hCAFEBA98, 32'h0000BA98);
    dRead("rWord", 2'b10, 32'h44, 32'hCAFEBA98, 32'hCAFEBA98);
    dRead("rByte", 2'b00, 32'h40, 32'h12345678, 32'h00000078);

    // Rejected accesses clear DReadData and skip memory.
    dErr("eWord", 2'b10, 32'h202);
    dErr("eHalf", 2'b01, 32'h201);
    dErr("eRsvd", 2'b11, 32'h200);

    // Reset mid-ACCESS with MemReady pending aborts the fetch.
    IReq = 1'b1; IAddress = 32'h300;
    tick;
    check("abort_memReq", 32'(MemReq), 32'd1);
    Reset = 1'b1; MemReady = 1'b1; MemReadData = 32'hBAD0BAD0;
    tick;
    check("abort_memReqOff", 32'(MemReq), 32'd0);
    check("abort_noAck", {30'd0, IAck, DAck}, 32'd0);
    check("abort_iData", IData, 32'h0);
    Reset = 1'b0; IReq = 1'b0;
    tick;
    tick;
    check("abort_ignoreReady", 32'(MemReq), 32'd0);
    check("abort_stillNoAck", {30'd0, IAck, DAck}, 32'd0);
    check("abort_iDataHold", IData, 32'h0);
    MemReady = 1'b0;
    tick;

    // Repeated ties straight after reset.
    runTie(t0, t1);
    runTie(t2, t3);
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    expGrants = 4'b0101;  // I, D, I, D (first entry in bit 3)
`else
    expGrants = 4'b1010;  // D, I, D, I
`endif
    check("tieOrder", {28'd0, t0, t1, t2, t3}, {28'd0, expGrants});

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
